sprite_fetch: RTL and testbench
===============================

Name: sprite_fetch

Overview:
- Produces the per-pixel sprite word and display flag consumed by the sprite/background display mux.
- Tracks the VGA raster (hcount/vcount) against a latched sprite position, computes the sprite ROM address including animation frame and integer scaling, and aligns ROM data with a registered display flag.
- Sits between the VGA timing generator, the position/controller logic and the synchronous sprite ROM.

Parameters:
- SPR_W, 32, sprite width in source pixels (power of 2)
- SPR_H, 32, sprite height in source pixels (power of 2)
- SCALE_SHIFT, 1, on-screen scale = 2**SCALE_SHIFT per axis
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM (power of 2)
- FRAME_DIV, 8, video frames per animation step (>=1)
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel tick; never high on two consecutive clk cycles
- hcount  in  10  current raster column
- vcount  in  10  current raster row
- video_on  in  1  raster in visible area
- pos_x  in  10  requested sprite left edge (screen pixels)
- pos_y  in  10  requested sprite top edge
- pos_wr  in  1  one-clk strobe: capture pos_x/pos_y as pending
- anim_en  in  1  1 = advance animation, 0 = hold current frame
- rom_addr  out  ADDR_W  sprite ROM read address
- rom_data  in  16  ROM word {rgb[11:0], alpha[3:0]}, valid 1 clk after rom_addr
- sprite  out  16  sprite word aligned with display
- display  out  1  current output pixel lies inside sprite box and visible area

Behaviour:
- Reset (rst_n=0 on a clk edge): rom_addr=0, sprite=0, display=0; active position=(0,0); pending position=(0,0); pending flag=0; anim frame=0; frame divider=0. Takes priority over all other events.
- Position capture: pos_wr=1 stores pos_x/pos_y in the pending registers and sets the pending flag. A later pos_wr before frame start overwrites the pending values (last write wins).
- Clamping at capture: pos_x > H_ACTIVE - (SPR_W<<SCALE_SHIFT) stores that maximum; pos_y clamps the same way against V_ACTIVE and SPR_H.
- Frame start is the pix_en cycle with vcount==V_ACTIVE and hcount==0.
  - If the pending flag is set, copy pending to active and clear the flag. This gives tear-free movement.
  - If pos_wr coincides with frame start, the new value is captured but applied only at the next frame start.
- Animation at frame start, when anim_en=1:
  - Divider increments.
  - When the divider reaches FRAME_DIV-1 it clears to 0 and the anim frame increments modulo NUM_FRAMES; NUM_FRAMES-1 wraps to 0.
  - anim_en=0 holds both the divider and the frame.
- Stage 1 (clk edge with pix_en=1):
  - dx = hcount - active_x and dy = vcount - active_y, computed at 11 bits, unsigned compare.
  - in_box = video_on, hcount >= active_x, dx < SPR_W<<SCALE_SHIFT, vcount >= active_y, dy < SPR_H<<SCALE_SHIFT.
  - col = dx>>SCALE_SHIFT; row = dy>>SCALE_SHIFT.
  - rom_addr <= frame*SPR_W*SPR_H + row*SPR_W + col when in_box, else 0.
  - in_box is registered as s1_valid.
- Stage 2 (next clk edge with pix_en=1):
  - sprite <= rom_data if s1_valid, else 16'h0000.
  - display <= s1_valid.
- Latency: raster position on tick N appears on sprite/display on tick N+2 (pix_en ticks). The timing generator delays bg/sync by 2 ticks to match.
- Outputs and rom_addr change only on pix_en cycles.
- Right/bottom boundaries: the last covered column is active_x + (SPR_W<<SCALE_SHIFT) - 1; the next column gives display=0.
- Alpha is not interpreted here. An alpha=0 word with display=1 is passed through, and the mux selects background.
- Mid-frame reset: all state returns to reset values; the sprite appears at (0,0) from the next pixel tick.

Test Plan:
1. Reset with defaults, pos (0,0), one pixel tick at hcount=0, vcount=0 -> rom_addr=0. Two ticks later display=1 and sprite equals ROM word 0. At hcount=64, display=0 and sprite=0.
2. pos_wr with (100,50) mid-frame -> the sprite stays at (0,0) until frame start (vcount=480, hcount=0). In the next frame, raster (101,51) gives rom_addr=0, and raster (103,53) gives rom_addr=1*32+1=33.
3. pos_wr with (700,470) -> the active position after frame start is clamped to (576,416). Raster (639,479) gives rom_addr=31*32+31=1023 and display=1.
4. anim_en=1, FRAME_DIV=8 -> the anim frame steps every 8 frames and wraps 3->0 after 32 frames. In frame 2, the pixel at the sprite origin reads rom_addr=2048. With anim_en=0 the frame holds.
5. video_on=0 inside the sprite box -> display=0 and sprite=0. Raster one row above active_y (vcount wrap, dy underflow) -> display=0.
6. rst_n=0 for 1 clk mid-line with display=1 and pending set -> the next clk shows display=0, sprite=0, rom_addr=0; the pending update is discarded and the frame is 0.

Source files
------------

// File: rtl/sprite_fetch.sv
// Sprite fetch: tracks the raster against a latched sprite position, forms the
// sprite ROM address (animation frame + integer scaling) and aligns the ROM
// word with a registered display flag two pixel ticks after the raster sample.
module sprite_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int SCALE_SHIFT = 1,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_DIV   = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = $clog2(NUM_FRAMES*SPR_W*SPR_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              video_on,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_wr,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       sprite,
    output logic              display
);

    localparam int BOX_W = SPR_W << SCALE_SHIFT;
    localparam int BOX_H = SPR_H << SCALE_SHIFT;
    localparam int MAX_X = H_ACTIVE - BOX_W;
    localparam int MAX_Y = V_ACTIVE - BOX_H;
    localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]        pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic              pend_vld_q, pend_vld_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [15:0]       sprite_q, sprite_d;
    logic              display_q, display_d;

    logic              frame_start;
    logic [10:0]       dx, dy, col, row;
    logic              in_box;
    logic [ADDR_W-1:0] addr_calc;

    // Raster-relative offsets, box test and ROM address for the current pixel.
    // The 11-bit subtraction lets a raster left of / above the sprite underflow
    // to a large value, which the explicit >= compares also reject.
    always_comb begin
        dx        = {1'b0, hcount} - {1'b0, act_x_q};
        dy        = {1'b0, vcount} - {1'b0, act_y_q};
        col       = dx >> SCALE_SHIFT;
        row       = dy >> SCALE_SHIFT;
        in_box    = video_on
                    && (hcount >= act_x_q) && (dx < 11'(BOX_W))
                    && (vcount >= act_y_q) && (dy < 11'(BOX_H));
        addr_calc = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                    + ADDR_W'(row) * ADDR_W'(SPR_W)
                    + ADDR_W'(col);
    end

    // Next-state: position capture/apply, animation stepping, two-stage pixel pipe.
    always_comb begin
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_vld_d = pend_vld_q;
        frame_d    = frame_q;
        div_d      = div_q;
        rom_addr_d = rom_addr_q;
        s1_valid_d = s1_valid_q;
        sprite_d   = sprite_q;
        display_d  = display_q;

        frame_start = pix_en && (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);

        if (frame_start) begin
            if (pend_vld_q) begin
                act_x_d    = pend_x_q;
                act_y_d    = pend_y_q;
                pend_vld_d = 1'b0;
            end
            if (anim_en) begin
                if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                    div_d   = '0;
                    frame_d = (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end

        // A write coinciding with frame start lands after the copy above, so it
        // stays pending until the following frame start.
        if (pos_wr) begin
            pend_x_d   = (pos_x > 10'(MAX_X)) ? 10'(MAX_X) : pos_x;
            pend_y_d   = (pos_y > 10'(MAX_Y)) ? 10'(MAX_Y) : pos_y;
            pend_vld_d = 1'b1;
        end

        if (pix_en) begin
            rom_addr_d = in_box ? addr_calc : '0;
            s1_valid_d = in_box;
            sprite_d   = s1_valid_q ? rom_data : 16'h0000;
            display_d  = s1_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_x_q    <= '0;
            act_y_q    <= '0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= '0;
            div_q      <= '0;
            rom_addr_q <= '0;
            s1_valid_q <= 1'b0;
            sprite_q   <= '0;
            display_q  <= 1'b0;
        end else begin
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= frame_d;
            div_q      <= div_d;
            rom_addr_q <= rom_addr_d;
            s1_valid_q <= s1_valid_d;
            sprite_q   <= sprite_d;
            display_q  <= display_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign sprite   = sprite_q;
    assign display  = display_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a synchronous ROM model.
module tb_sprite_fetch;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_en;
    logic [9:0]        hcount, vcount, pos_x, pos_y;
    logic              video_on, pos_wr, anim_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       sprite;
    logic              display;

    int n_chk = 0;
    int n_bad = 0;
    int cur_h = 0, cur_v = 0;
    bit prev_box = 1'b0;
    int prev_addr = 0;

    typedef struct {
        int h;
        int v;
        bit von;
        int ea;
        bit eb;
    } vec_t;

    vec_t tbl[9];

    sprite_fetch dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .pos_x(pos_x), .pos_y(pos_y), .pos_wr(pos_wr),
        .anim_en(anim_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .sprite(sprite), .display(display)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a, 4'h5};
    endfunction

    // Synchronous ROM: data one clk after address.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @(%0d,%0d): got 0x%0h, want 0x%0h", name, cur_h, cur_v, act, exp);
        end
    endtask

    // One pixel tick; checks the address of this tick and the outputs of the previous one.
    task automatic step(input int h, input int v, input bit von, input bit wr,
                        input int px, input int py, input int ea, input bit eb);
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); video_on = von;
        pos_wr = wr; pos_x = 10'(px); pos_y = 10'(py);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0; pos_wr = 1'b0;
        cur_h = h; cur_v = v;
        chk("rom_addr", int'(rom_addr), ea);
        chk("display", int'(display), int'(prev_box));
        chk("sprite", int'(sprite), prev_box ? int'(rom_word(ADDR_W'(prev_addr))) : 0);
        prev_box  = eb;
        prev_addr = ea;
    endtask

    task automatic frame_start();
        step(0, 480, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic write_pos(input int x, input int y);
        @(negedge clk);
        pos_x = 10'(x); pos_y = 10'(y); pos_wr = 1'b1;
        @(negedge clk);
        pos_wr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0,  0,  1'b1, 0,    1'b1};
        tbl[1] = '{1,  0,  1'b1, 0,    1'b1};
        tbl[2] = '{2,  0,  1'b1, 1,    1'b1};
        tbl[3] = '{63, 0,  1'b1, 31,   1'b1};
        tbl[4] = '{64, 0,  1'b1, 0,    1'b0};
        tbl[5] = '{2,  2,  1'b1, 33,   1'b1};
        tbl[6] = '{2,  2,  1'b0, 0,    1'b0};
        tbl[7] = '{63, 63, 1'b1, 1023, 1'b1};
        tbl[8] = '{63, 64, 1'b1, 0,    1'b0};

        rst_n = 1'b0; pix_en = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
        pos_x = '0; pos_y = '0; pos_wr = 1'b0; anim_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rom_addr", int'(rom_addr), 0);
        chk("reset sprite", int'(sprite), 0);
        chk("reset display", int'(display), 0);
        rst_n = 1'b1;

        // Default position (0,0), frame 0: addressing, scaling, right/bottom edges.
        foreach (tbl[i])
            step(tbl[i].h, tbl[i].v, tbl[i].von, 1'b0, 0, 0, tbl[i].ea, tbl[i].eb);

        // Mid-frame move is deferred to frame start.
        write_pos(100, 50);
        step(0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        frame_start();
        step(101, 51, 1'b1, 1'b0, 0, 0, 0,    1'b1);
        step(103, 53, 1'b1, 1'b0, 0, 0, 33,   1'b1);
        step(99,  51, 1'b1, 1'b0, 0, 0, 0,    1'b0);
        step(100, 49, 1'b1, 1'b0, 0, 0, 0,    1'b0);
        step(163, 113, 1'b1, 1'b0, 0, 0, 1023, 1'b1);
        step(164, 113, 1'b1, 1'b0, 0, 0, 0,    1'b0);

        // Write on the frame-start tick waits one more frame.
        step(0, 480, 1'b0, 1'b1, 200, 100, 0, 1'b0);
        step(100, 50,  1'b1, 1'b0, 0, 0, 0, 1'b1);
        step(200, 100, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        frame_start();
        step(200, 100, 1'b1, 1'b0, 0, 0, 0, 1'b1);

        // Last write before frame start wins.
        write_pos(10, 10);
        write_pos(300, 200);
        frame_start();
        step(300, 200, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        step(10,  10,  1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Clamp to (576,416); bottom-right visible pixel is the last sprite pixel.
        write_pos(700, 470);
        frame_start();
        step(639, 479, 1'b1, 1'b0, 0, 0, 1023, 1'b1);
        step(576, 416, 1'b1, 1'b0, 0, 0, 0,    1'b1);
        step(575, 416, 1'b1, 1'b0, 0, 0, 0,    1'b0);
        step(576, 415, 1'b1, 1'b0, 0, 0, 0,    1'b0);

        // Animation: one frame step every 8 frame starts, wrapping after 4 steps.
        anim_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            frame_start();
            if (k == 7 || k == 8 || k == 16 || k == 24 || k == 32 || k == 40)
                step(576, 416, 1'b1, 1'b0, 0, 0, ((k / 8) % 4) * 1024, 1'b1);
        end
        anim_en = 1'b0;
        for (int k = 0; k < 10; k++) frame_start();
        step(576, 416, 1'b1, 1'b0, 0, 0, 1024, 1'b1);

        // video_on low inside the box, then an in-box pixel drained through.
        step(600, 430, 1'b0, 1'b0, 0, 0, 0,    1'b0);
        step(600, 430, 1'b1, 1'b0, 0, 0, 1260, 1'b1);
        step(0,   0,   1'b0, 1'b0, 0, 0, 0,    1'b0);

        // Mid-line reset with display high and a pending move.
        write_pos(50, 60);
        step(580, 420, 1'b1, 1'b0, 0, 0, 1090, 1'b1);
        step(581, 420, 1'b1, 1'b0, 0, 0, 1090, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_h = -1; cur_v = -1;
        chk("midreset rom_addr", int'(rom_addr), 0);
        chk("midreset sprite", int'(sprite), 0);
        chk("midreset display", int'(display), 0);
        prev_box = 1'b0; prev_addr = 0;
        step(70, 70, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        frame_start();
        step(70, 70, 1'b1, 1'b0, 0, 0, 0,  1'b0);
        step(2,  2,  1'b1, 1'b0, 0, 0, 33, 1'b1);
        step(0,  0,  1'b0, 1'b0, 0, 0, 0,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
